display_scheduler: RTL and testbench
====================================

# display_scheduler

Controller in front of the multiplexed 4-digit display. Decides each cycle whether the display shows parking status (capacity/empty slots, mode 0) or the elapsed-time view (mm:ss, mode 1), and owns the mm:ss elapsed-time counter feeding it. Handles user view requests, automatic return to status view, and a forced status view after car entry/exit events. Runs on the 500 Hz display clock; its `mode`, `minutes` and `seconds` outputs connect directly to the display driver.

## Interface
- TICKS_PER_SEC, 500, clk_500Hz cycles per second
- HOLD_SEC, 5, seconds the timer view stays up without a new request
- EVENT_SEC, 2, seconds of forced status view after a car event

- clk_500Hz  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock clk_500Hz
- view_req  in  1  single-cycle pulse: toggle between status and timer view
- car_event  in  1  single-cycle pulse: car entered or left
- timer_run  in  1  level: elapsed timer counts while high
- timer_clear  in  1  single-cycle pulse: zero the elapsed timer
- mode  out  1  0 = status view, 1 = timer view (registered)
- minutes  out  6  elapsed minutes, 0..59
- seconds  out  6  elapsed seconds, 0..59
- timer_ovf  out  1  sticky; set when the timer saturates at 59:59
- view_state  out  2  current FSM state: 0 STATUS, 1 TIMER, 2 EVENT

## Operation
- All outputs are registered. At reset: mode=0, minutes=0, seconds=0, timer_ovf=0, view_state=STATUS, all prescalers and counters=0, saved_state=STATUS.
- Elapsed timer:
  - The prescaler counts 0..TICKS_PER_SEC-1 only while timer_run=1. When timer_run=0 it holds its value; it does not clear.
  - Prescaler wrap while running gives sec_tick. seconds then increments. At 59, seconds goes to 0 and minutes increments.
  - At 59:59, sec_tick leaves the count at 59:59 and sets timer_ovf.
  - timer_clear zeroes the prescaler, seconds, minutes and timer_ovf. If timer_clear and sec_tick occur in the same cycle, clear wins.
- View FSM, with a dwell counter that is cleared on every state entry and counts every cycle:
  - STATUS (mode=0):
    - view_req goes to TIMER.
    - car_event goes to EVENT, with saved_state=STATUS.
  - TIMER (mode=1):
    - view_req goes to STATUS.
    - The dwell counter reaching HOLD_SEC*TICKS_PER_SEC-1 goes to STATUS.
    - car_event goes to EVENT, with saved_state=TIMER.
  - EVENT (mode=0):
    - The dwell counter reaching EVENT_SEC*TICKS_PER_SEC-1 returns to saved_state.
    - car_event restarts the dwell counter; saved_state is unchanged.
    - view_req is ignored.
- Priority in one cycle: car_event > dwell expiry > view_req. A view_req coinciding with car_event is dropped.
- Dwell counter width is sized for max(HOLD_SEC, EVENT_SEC)*TICKS_PER_SEC. Timer and dwell prescalers are independent; the dwell counter runs regardless of timer_run.

## Timing
- Inputs are sampled on posedge clk_500Hz. Responses appear on the next edge:
  - view_req or car_event high in cycle t gives new mode/view_state visible in cycle t+1.
  - sec_tick in cycle t gives an updated seconds/minutes value in cycle t+1.
- Dwell timing: with entry at edge t, the state is held for exactly LIMIT cycles, leaving at edge t+LIMIT.
  - LIMIT = HOLD_SEC*TICKS_PER_SEC for TIMER.
  - LIMIT = EVENT_SEC*TICKS_PER_SEC for EVENT.
- A returning TIMER state (EVENT→TIMER) gets a fresh full hold period.
- reset low at any edge forces all reset values at that edge, mid-count or mid-state included. Pulses coinciding with reset are discarded.

## Test plan
All scenarios use TICKS_PER_SEC=4, HOLD_SEC=3, EVENT_SEC=2.
1. Reset, then timer_run=1 for 4*61 cycles → seconds=1, minutes=1 at cycle 244. timer_run=0 for 10 cycles → values and prescaler frozen.
2. Preload near 59:58 by running, then 8 more ticks → output holds 59:59 and timer_ovf=1. timer_clear → 00:00 and timer_ovf=0 next cycle. timer_clear coincident with sec_tick → 00:00.
3. view_req at cycle 10 → mode=1 at cycle 11, mode=0 at cycle 23 (12-cycle hold). Second view_req at cycle 15 → mode=0 at cycle 16.
4. In TIMER, car_event → mode=0 and view_state=2 next cycle. After 8 cycles mode=1 again, then stays up another full 12 cycles.
5. In EVENT, car_event at dwell 5 → EVENT extended to 8 cycles after the second event. view_req during EVENT → no effect. view_req and car_event in the same cycle from STATUS → EVENT.
6. Assert reset while in TIMER with timer at 00:07 → mode=0, 00:00, view_state=0 at that edge. A view_req in the reset cycle is not acted on.

Source files
------------

// File: rtl/display_scheduler.sv
// View controller for the 4-digit parking display: selects status vs. mm:ss view
// and owns the saturating elapsed-time counter shown in the timer view.
module display_scheduler #(
  parameter int TICKS_PER_SEC = 500,
  parameter int HOLD_SEC      = 5,
  parameter int EVENT_SEC     = 2
) (
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic       view_req,
  input  logic       car_event,
  input  logic       timer_run,
  input  logic       timer_clear,
  output logic       mode,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       timer_ovf,
  output logic [1:0] view_state
);

  localparam int PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DWELL_MAX = ((HOLD_SEC > EVENT_SEC) ? HOLD_SEC : EVENT_SEC) * TICKS_PER_SEC;
  localparam int DW        = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [DW-1:0] HOLD_LAST  = DW'(HOLD_SEC * TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] EVENT_LAST = DW'(EVENT_SEC * TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_STATUS = 2'd0,
    ST_TIMER  = 2'd1,
    ST_EVENT  = 2'd2
  } view_t;

  logic [PW-1:0] pre_r;
  logic [5:0]    sec_r;
  logic [5:0]    min_r;
  logic          ovf_r;
  logic          sec_tick_s;
  logic          timer_full_s;

  view_t         state_r;
  view_t         state_next_s;
  view_t         saved_r;
  view_t         saved_next_s;
  logic [DW-1:0] dwell_r;
  logic          dwell_clr_s;
  logic          mode_r;
  logic          mode_next_s;

  assign sec_tick_s   = timer_run && (pre_r == PRE_LAST);
  assign timer_full_s = (min_r == 6'd59) && (sec_r == 6'd59);

  // Elapsed timer: prescaler holds while stopped; count saturates at 59:59 and flags overflow
  always_ff @(posedge clk_500Hz) begin
    if (!reset || timer_clear) begin
      pre_r <= '0;
      sec_r <= 6'd0;
      min_r <= 6'd0;
      ovf_r <= 1'b0;
    end else if (sec_tick_s) begin
      pre_r <= '0;
      if (timer_full_s) begin
        ovf_r <= 1'b1;
      end else if (sec_r == 6'd59) begin
        sec_r <= 6'd0;
        min_r <= min_r + 6'd1;
      end else begin
        sec_r <= sec_r + 6'd1;
      end
    end else if (timer_run) begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // View state register with the state remembered across a forced event view
  always_ff @(posedge clk_500Hz) begin
    if (!reset) begin
      state_r <= ST_STATUS;
      saved_r <= ST_STATUS;
    end else begin
      state_r <= state_next_s;
      saved_r <= saved_next_s;
    end
  end

  // Dwell counter: restarts on every state entry, free-runs otherwise
  always_ff @(posedge clk_500Hz) begin
    if (!reset || dwell_clr_s) begin
      dwell_r <= '0;
    end else begin
      dwell_r <= dwell_r + DWELL_ONE;
    end
  end

  // Next-state logic; car_event outranks dwell expiry, which outranks view_req
  always_comb begin
    state_next_s = state_r;
    saved_next_s = saved_r;
    dwell_clr_s  = 1'b0;
    case (state_r)
      ST_STATUS: begin
        if (car_event) begin
          state_next_s = ST_EVENT;
          saved_next_s = ST_STATUS;
          dwell_clr_s  = 1'b1;
        end else if (view_req) begin
          state_next_s = ST_TIMER;
          dwell_clr_s  = 1'b1;
        end else begin
          state_next_s = ST_STATUS;
        end
      end
      ST_TIMER: begin
        if (car_event) begin
          state_next_s = ST_EVENT;
          saved_next_s = ST_TIMER;
          dwell_clr_s  = 1'b1;
        end else if (dwell_r == HOLD_LAST || view_req) begin
          state_next_s = ST_STATUS;
          dwell_clr_s  = 1'b1;
        end else begin
          state_next_s = ST_TIMER;
        end
      end
      ST_EVENT: begin
        if (car_event) begin
          dwell_clr_s  = 1'b1;
        end else if (dwell_r == EVENT_LAST) begin
          state_next_s = saved_r;
          dwell_clr_s  = 1'b1;
        end else begin
          state_next_s = ST_EVENT;
        end
      end
      default: begin
        state_next_s = ST_STATUS;
        saved_next_s = ST_STATUS;
        dwell_clr_s  = 1'b1;
      end
    endcase
  end

  // Output decode from the upcoming state so mode lands on the same edge as the state
  always_comb begin
    if (state_next_s == ST_TIMER) begin
      mode_next_s = 1'b1;
    end else begin
      mode_next_s = 1'b0;
    end
  end

  // Registered view mode
  always_ff @(posedge clk_500Hz) begin
    if (!reset) begin
      mode_r <= 1'b0;
    end else begin
      mode_r <= mode_next_s;
    end
  end

  assign mode       = mode_r;
  assign minutes    = min_r;
  assign seconds    = sec_r;
  assign timer_ovf  = ovf_r;
  assign view_state = state_r;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus random traffic, all checked
// each cycle against an elapsed-cycle / entry-time reference model.
module tb_display_scheduler;

  localparam int T = 4;
  localparam int H = 3;
  localparam int E = 2;

  logic       clk_500Hz = 1'b0;
  logic       reset = 1'b0;
  logic       view_req = 1'b0;
  logic       car_event = 1'b0;
  logic       timer_run = 1'b0;
  logic       timer_clear = 1'b0;
  logic       mode;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       timer_ovf;
  logic [1:0] view_state;

  int total = 0;
  int bad = 0;

  // Reference model: running cycles since last clear, view state and its entry edge
  int edge_no = 0;
  int run_cycles = 0;
  int m_state = 0;
  int m_saved = 0;
  int m_entry = 0;

  display_scheduler #(.TICKS_PER_SEC(T), .HOLD_SEC(H), .EVENT_SEC(E)) dut (
    .clk_500Hz  (clk_500Hz),
    .reset      (reset),
    .view_req   (view_req),
    .car_event  (car_event),
    .timer_run  (timer_run),
    .timer_clear(timer_clear),
    .mode       (mode),
    .minutes    (minutes),
    .seconds    (seconds),
    .timer_ovf  (timer_ovf),
    .view_state (view_state)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    int age;
    age = edge_no - m_entry;
    if (!reset) begin
      run_cycles = 0;
      m_state = 0;
      m_saved = 0;
      m_entry = edge_no;
    end else begin
      if (timer_clear) run_cycles = 0;
      else if (timer_run) run_cycles++;
      if (car_event) begin
        if (m_state != 2) m_saved = m_state;
        m_state = 2;
        m_entry = edge_no;
      end else if ((m_state == 1 && age == H * T) || (m_state == 2 && age == E * T)) begin
        m_state = (m_state == 2) ? m_saved : 0;
        m_entry = edge_no;
      end else if (view_req && m_state != 2) begin
        m_state = (m_state == 1) ? 0 : 1;
        m_entry = edge_no;
      end
    end
  endtask

  task automatic check_model();
    int ts;
    int disp;
    ts = run_cycles / T;
    disp = (ts > 3599) ? 3599 : ts;
    chk("mode", {31'd0, mode}, (m_state == 1) ? 32'd1 : 32'd0);
    chk("view_state", {30'd0, view_state}, m_state);
    chk("minutes", {26'd0, minutes}, disp / 60);
    chk("seconds", {26'd0, seconds}, disp % 60);
    chk("timer_ovf", {31'd0, timer_ovf}, (ts >= 3600) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_500Hz);
      edge_no++;
      model_edge();
      #1;
      check_model();
    end
  endtask

  task automatic exp_time(input string tag, input int mi, input int s, input int ovf);
    chk({tag, "_min"}, {26'd0, minutes}, mi);
    chk({tag, "_sec"}, {26'd0, seconds}, s);
    chk({tag, "_ovf"}, {31'd0, timer_ovf}, ovf);
  endtask

  task automatic exp_view(input string tag, input int md, input int vs);
    chk({tag, "_mode"}, {31'd0, mode}, md);
    chk({tag, "_vs"}, {30'd0, view_state}, vs);
  endtask

  initial begin
    // Reset values
    reset = 1'b0;
    step(2);
    exp_time("rst", 0, 0, 0);
    exp_view("rst", 0, 0);
    reset = 1'b1;

    // 1: count to 1:01, then freeze and prove the prescaler held
    timer_run = 1'b1;
    step(244);
    exp_time("t1_244", 1, 1, 0);
    step(2);
    timer_run = 1'b0;
    step(10);
    exp_time("t1_frozen", 1, 1, 0);
    timer_run = 1'b1;
    step(1);
    exp_time("t1_resume1", 1, 1, 0);
    step(1);
    exp_time("t1_resume2", 1, 2, 0);
    timer_run = 1'b0;

    // 2: saturation at 59:59 and clear behaviour
    timer_clear = 1'b1; step(1); timer_clear = 1'b0;
    timer_run = 1'b1;
    step(3598 * T);
    exp_time("t2_5958", 59, 58, 0);
    step(T);
    exp_time("t2_5959", 59, 59, 0);
    step(T);
    exp_time("t2_sat", 59, 59, 1);
    step(6 * T);
    exp_time("t2_hold", 59, 59, 1);
    timer_run = 1'b0;
    timer_clear = 1'b1; step(1); timer_clear = 1'b0;
    exp_time("t2_clr", 0, 0, 0);
    timer_run = 1'b1;
    step(T - 1);
    timer_clear = 1'b1; step(1); timer_clear = 1'b0;
    exp_time("t2_clr_tick", 0, 0, 0);
    step(T - 1);
    exp_time("t2_post_clr", 0, 0, 0);
    step(1);
    exp_time("t2_post_clr_tick", 0, 1, 0);
    timer_run = 1'b0;

    // 3: timer view hold and toggle back
    reset = 1'b0; step(1); reset = 1'b1;
    step(9);
    view_req = 1'b1; step(1); view_req = 1'b0;
    exp_view("t3_on", 1, 1);
    step(H * T - 1);
    exp_view("t3_held", 1, 1);
    step(1);
    exp_view("t3_expire", 0, 0);
    view_req = 1'b1; step(1); view_req = 1'b0;
    step(4);
    view_req = 1'b1; step(1); view_req = 1'b0;
    exp_view("t3_toggle", 0, 0);

    // 4: car event from TIMER returns to TIMER with a fresh hold
    view_req = 1'b1; step(1); view_req = 1'b0;
    step(3);
    car_event = 1'b1; step(1); car_event = 1'b0;
    exp_view("t4_event", 0, 2);
    step(E * T - 1);
    exp_view("t4_event_held", 0, 2);
    step(1);
    exp_view("t4_back", 1, 1);
    step(H * T - 1);
    exp_view("t4_fresh", 1, 1);
    step(1);
    exp_view("t4_expire", 0, 0);

    // 5: event restart, ignored view_req, coincident pulses
    car_event = 1'b1; step(1); car_event = 1'b0;
    step(5);
    car_event = 1'b1; step(1); car_event = 1'b0;
    step(3);
    view_req = 1'b1; step(1); view_req = 1'b0;
    exp_view("t5_ignored", 0, 2);
    step(E * T - 5);
    exp_view("t5_extended", 0, 2);
    step(1);
    exp_view("t5_return", 0, 0);
    view_req = 1'b1; car_event = 1'b1; step(1);
    view_req = 1'b0; car_event = 1'b0;
    exp_view("t5_coincide", 0, 2);
    step(E * T);
    exp_view("t5_done", 0, 0);

    // 6: reset mid-TIMER with the timer running discards everything
    timer_clear = 1'b1; step(1); timer_clear = 1'b0;
    timer_run = 1'b1;
    step(6 * T);
    view_req = 1'b1; step(1); view_req = 1'b0;
    step(T - 1);
    exp_time("t6_pre", 0, 7, 0);
    exp_view("t6_pre", 1, 1);
    reset = 1'b0; view_req = 1'b1; step(1);
    exp_time("t6_rst", 0, 0, 0);
    exp_view("t6_rst", 0, 0);
    reset = 1'b1; view_req = 1'b0; timer_run = 1'b0;
    step(1);
    exp_view("t6_after", 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      view_req    = ($urandom_range(7) == 0);
      car_event   = ($urandom_range(15) == 0);
      timer_clear = ($urandom_range(63) == 0);
      if ($urandom_range(31) == 0) timer_run = ~timer_run;
      reset       = ($urandom_range(499) != 0);
      step(1);
    end
    view_req = 1'b0; car_event = 1'b0; timer_clear = 1'b0; reset = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
